// File: rtl/window_scheduler.sv
// Window scheduler: tracks ring-buffer slot completions and issues analysis windows to the hannifier.
// Optional WSCHED_OVERRUN_CNT_EN adds a saturating overrun_count output.
module window_scheduler #(
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned SLOT_LOG2 = 11,
   parameter int unsigned WIN_SLOTS = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        wr_valid,
   input  logic [ADDR_W-1:0]           wr_addr,
   output logic                        win_go,
   output logic [ADDR_W-SLOT_LOG2-1:0] win_start,
   input  logic                        win_done,
   output logic                        busy,
   output logic                        overrun
`ifdef WSCHED_OVERRUN_CNT_EN
   ,
   output logic [15:0]                 overrun_count
`endif
);

   localparam int unsigned SLOT_W = ADDR_W - SLOT_LOG2;
   localparam int unsigned FILL_W = $clog2(WIN_SLOTS + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_ISSUE, ST_ACTIVE, ST_WAIT} state_t;

   state_t             state_q, state_d;
   logic               slot_done, ready, in_flight;
   logic [SLOT_W-1:0]  cur_slot, ready_start;
   logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
   logic               pend_q, pend_d;
   logic [SLOT_W-1:0]  pend_start_q, pend_start_d, start_q, start_d;
   logic               win_go_q, win_go_d, busy_q, busy_d, overrun_q, overrun_d;
   logic [15:0]        ocnt_q, ocnt_d;

   assign slot_done   = wr_valid && (&wr_addr[SLOT_LOG2-1:0]);
   assign cur_slot    = wr_addr[ADDR_W-1:SLOT_LOG2];
   assign fill_inc    = (fill_q < FILL_W'(WIN_SLOTS)) ? fill_q + FILL_W'(1) : fill_q;
   assign ready       = slot_done && (state_q != ST_IDLE) && (fill_inc == FILL_W'(WIN_SLOTS));
   assign ready_start = cur_slot - SLOT_W'(WIN_SLOTS - 1);
   assign in_flight   = (state_q == ST_ISSUE) || (state_q == ST_ACTIVE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (enable) state_d = ST_FILL;
         ST_FILL,
         ST_WAIT: begin
            if (!enable)    state_d = ST_IDLE;
            else if (ready) state_d = ST_ISSUE;
         end
         ST_ISSUE:  state_d = ST_ACTIVE;
         ST_ACTIVE: begin
            if (win_done) begin
               if (!enable)              state_d = ST_IDLE;
               else if (pend_q || ready) state_d = ST_ISSUE;
               else                      state_d = ST_WAIT;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      fill_d       = fill_q;
      pend_d       = pend_q;
      pend_start_d = pend_start_q;
      start_d      = start_q;
      overrun_d    = overrun_q;
      ocnt_d       = ocnt_q;

      if (state_q == ST_IDLE) begin
         if (enable) begin
            fill_d    = '0;
            pend_d    = 1'b0;
            overrun_d = 1'b0;
            ocnt_d    = '0;
         end
      end else if (slot_done) begin
         fill_d = fill_inc;
      end

      // One pending slot; a newer ready window replaces it and counts as an overrun
      if (in_flight && !enable) begin
         pend_d = 1'b0;
      end else if (in_flight && ready) begin
         if (pend_q) begin
            overrun_d = 1'b1;
            ocnt_d    = (ocnt_q != 16'hFFFF) ? ocnt_q + 16'd1 : ocnt_q;
         end
         pend_d       = 1'b1;
         pend_start_d = ready_start;
      end

      if ((state_q == ST_FILL || state_q == ST_WAIT) && enable && ready)
         start_d = ready_start;

      if (state_q == ST_ACTIVE && win_done && enable && pend_d) begin
         start_d = pend_start_d;
         pend_d  = 1'b0;
      end

      if (state_d == ST_IDLE) start_d = '0;

      win_go_d = (state_d == ST_ISSUE);
      busy_d   = (state_d == ST_ISSUE) || (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_q       <= '0;
         pend_q       <= 1'b0;
         pend_start_q <= '0;
         start_q      <= '0;
         win_go_q     <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         ocnt_q       <= '0;
      end else begin
         fill_q       <= fill_d;
         pend_q       <= pend_d;
         pend_start_q <= pend_start_d;
         start_q      <= start_d;
         win_go_q     <= win_go_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         ocnt_q       <= ocnt_d;
      end
   end

   assign win_go    = win_go_q;
   assign win_start = start_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
`ifdef WSCHED_OVERRUN_CNT_EN
   assign overrun_count = ocnt_q;
`else
   logic unused_ocnt;
   assign unused_ocnt = ^ocnt_q;
`endif

endmodule
